// File: rtl/jtag_tap_responder_pkg.sv
// Shared types and defaults for the simulated JTAG TAP responder.
// Holds the 1149.1 state encoding, DR select enum and capture pattern.
package jtag_tap_pkg;

    // Standard IEEE 1149.1 TAP controller state encoding.
    typedef enum logic [3:0] {
        EXIT2_DR   = 4'h0,
        EXIT1_DR   = 4'h1,
        SHIFT_DR   = 4'h2,
        PAUSE_DR   = 4'h3,
        SELECT_IR  = 4'h4,
        UPDATE_DR  = 4'h5,
        CAPTURE_DR = 4'h6,
        SELECT_DR  = 4'h7,
        EXIT2_IR   = 4'h8,
        EXIT1_IR   = 4'h9,
        SHIFT_IR   = 4'hA,
        PAUSE_IR   = 4'hB,
        RUN_IDLE   = 4'hC,
        UPDATE_IR  = 4'hD,
        CAPTURE_IR = 4'hE,
        TEST_RESET = 4'hF
    } tap_state_t;

    // Which data register sits between TDI and TDO.
    typedef enum logic [1:0] {
        DR_BYPASS,
        DR_IDCODE,
        DR_USER
    } dr_sel_t;

    localparam logic [31:0] DEFAULT_IDCODE_VALUE = 32'h149511C3;
    localparam logic [3:0]  DEFAULT_IDCODE_INSTR = 4'b0001;
    localparam logic [3:0]  DEFAULT_USER_INSTR   = 4'b1000;

    // Capture-IR pattern: zeros above a mandatory 2'b01 in the low bits.
    function automatic logic [31:0] capture_ir_pattern();
        return 32'b01;
    endfunction

endpackage

// File: rtl/jtag_tap_responder_if.sv
// JTAG pin bundle between the bridge (master) and the TAP (slave).
// Members: TMS, TCK, TRST (active low), TDI toward TAP; TDO back.
interface jtag_tap_responder_if;

    logic jtag_tms_i;
    logic jtag_tck_i;
    logic jtag_trst_i;
    logic jtag_tdi_i;
    logic jtag_tdo_o;

    modport master (
        output jtag_tms_i,
        output jtag_tck_i,
        output jtag_trst_i,
        output jtag_tdi_i,
        input  jtag_tdo_o
    );

    modport slave (
        input  jtag_tms_i,
        input  jtag_tck_i,
        input  jtag_trst_i,
        input  jtag_tdi_i,
        output jtag_tdo_o
    );

endinterface

// File: rtl/jtag_tap_input_sync.sv
// Two-flop synchronisers for the JTAG pins plus TCK edge detection.
// In: clk_i, rst_i, raw pins. Out: synced TMS/TDI/TRST_n, tck_rise/fall pulses.
module jtag_tap_input_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic tms_i,
    input  logic tck_i,
    input  logic trst_n_i,
    input  logic tdi_i,
    output logic tms_o,
    output logic trst_n_o,
    output logic tdi_o,
    output logic tck_rise_o,
    output logic tck_fall_o
);

    logic [1:0] tms_q;
    logic [1:0] tck_q;
    logic [1:0] trst_q;
    logic [1:0] tdi_q;
    logic       tck_prev_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tms_q      <= 2'b00;
            tck_q      <= 2'b00;
            // TRST idles deasserted so reset does not look like a TRST pulse.
            trst_q     <= 2'b11;
            tdi_q      <= 2'b00;
            tck_prev_q <= 1'b0;
        end else begin
            tms_q      <= {tms_q[0], tms_i};
            tck_q      <= {tck_q[0], tck_i};
            trst_q     <= {trst_q[0], trst_n_i};
            tdi_q      <= {tdi_q[0], tdi_i};
            tck_prev_q <= tck_q[1];
        end
    end

    assign tms_o      = tms_q[1];
    assign trst_n_o   = trst_q[1];
    assign tdi_o      = tdi_q[1];
    assign tck_rise_o = tck_q[1] & ~tck_prev_q;
    assign tck_fall_o = ~tck_q[1] & tck_prev_q;

endmodule

// File: rtl/jtag_tap_responder.sv
// Simulated 1149.1 TAP with IDCODE, BYPASS and one user DR, clocked by system_clk.
// Ports: system_clk/rst, JTAG pin interface, user capture/update data, state and IR.
module jtag_tap_responder
    import jtag_tap_pkg::*;
#(
    parameter int unsigned           IR_WIDTH      = 4,
    parameter logic [31:0]           IDCODE_VALUE  = DEFAULT_IDCODE_VALUE,
    parameter logic [IR_WIDTH-1:0]   IDCODE_INSTR  = IR_WIDTH'(DEFAULT_IDCODE_INSTR),
    parameter logic [IR_WIDTH-1:0]   USER_INSTR    = IR_WIDTH'(DEFAULT_USER_INSTR),
    parameter int unsigned           USER_DR_WIDTH = 32
) (
    input  logic                     system_clk,
    input  logic                     system_rst,
    jtag_tap_responder_if.slave      jtag,
    input  logic [USER_DR_WIDTH-1:0] user_dr_capture_data_i,
    output logic [USER_DR_WIDTH-1:0] user_dr_update_data_o,
    output logic                     user_dr_update_strobe_o,
    output logic [3:0]               tap_state_o,
    output logic [IR_WIDTH-1:0]      ir_o
);

    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(capture_ir_pattern());

    logic tms_s;
    logic tdi_s;
    logic trst_n_s;
    logic tck_rise;
    logic tck_fall;

    jtag_tap_input_sync u_sync (
        .clk_i      (system_clk),
        .rst_i      (system_rst),
        .tms_i      (jtag.jtag_tms_i),
        .tck_i      (jtag.jtag_tck_i),
        .trst_n_i   (jtag.jtag_trst_i),
        .tdi_i      (jtag.jtag_tdi_i),
        .tms_o      (tms_s),
        .trst_n_o   (trst_n_s),
        .tdi_o      (tdi_s),
        .tck_rise_o (tck_rise),
        .tck_fall_o (tck_fall)
    );

    tap_state_t               state_q, state_d, tap_next;
    logic [IR_WIDTH-1:0]      ir_q, ir_d;
    logic [IR_WIDTH-1:0]      ir_sr_q, ir_sr_d;
    logic [31:0]              id_sr_q, id_sr_d;
    logic                     byp_q, byp_d;
    logic [USER_DR_WIDTH-1:0] usr_sr_q, usr_sr_d;
    logic [USER_DR_WIDTH-1:0] upd_q, upd_d;
    logic                     stb_q, stb_d;
    logic                     tdo_q, tdo_d;
    dr_sel_t                  dr_sel;
    logic                     dr_tdo;

    // 1149.1 transition table driven by the synchronised TMS.
    always_comb begin
        tap_next = state_q;
        unique case (state_q)
            TEST_RESET: tap_next = tms_s ? TEST_RESET : RUN_IDLE;
            RUN_IDLE:   tap_next = tms_s ? SELECT_DR  : RUN_IDLE;
            SELECT_DR:  tap_next = tms_s ? SELECT_IR  : CAPTURE_DR;
            CAPTURE_DR: tap_next = tms_s ? EXIT1_DR   : SHIFT_DR;
            SHIFT_DR:   tap_next = tms_s ? EXIT1_DR   : SHIFT_DR;
            EXIT1_DR:   tap_next = tms_s ? UPDATE_DR  : PAUSE_DR;
            PAUSE_DR:   tap_next = tms_s ? EXIT2_DR   : PAUSE_DR;
            EXIT2_DR:   tap_next = tms_s ? UPDATE_DR  : SHIFT_DR;
            UPDATE_DR:  tap_next = tms_s ? SELECT_DR  : RUN_IDLE;
            SELECT_IR:  tap_next = tms_s ? TEST_RESET : CAPTURE_IR;
            CAPTURE_IR: tap_next = tms_s ? EXIT1_IR   : SHIFT_IR;
            SHIFT_IR:   tap_next = tms_s ? EXIT1_IR   : SHIFT_IR;
            EXIT1_IR:   tap_next = tms_s ? UPDATE_IR  : PAUSE_IR;
            PAUSE_IR:   tap_next = tms_s ? EXIT2_IR   : PAUSE_IR;
            EXIT2_IR:   tap_next = tms_s ? UPDATE_IR  : SHIFT_IR;
            UPDATE_IR:  tap_next = tms_s ? SELECT_DR  : RUN_IDLE;
        endcase
    end

    // TRST wins over a coincident TCK rise.
    always_comb begin
        state_d = state_q;
        if (!trst_n_s) begin
            state_d = TEST_RESET;
        end else if (tck_rise) begin
            state_d = tap_next;
        end
    end

    // Unrecognised opcodes, including all-ones, fall back to BYPASS.
    always_comb begin
        dr_sel = DR_BYPASS;
        if (ir_q == IDCODE_INSTR) begin
            dr_sel = DR_IDCODE;
        end else if (ir_q == USER_INSTR) begin
            dr_sel = DR_USER;
        end
    end

    always_comb begin
        unique case (dr_sel)
            DR_IDCODE: dr_tdo = id_sr_q[0];
            DR_USER:   dr_tdo = usr_sr_q[0];
            default:   dr_tdo = byp_q;
        endcase
    end

    // Capture/shift act on TCK rise in the current state; update and TDO on fall.
    always_comb begin
        ir_sr_d  = ir_sr_q;
        id_sr_d  = id_sr_q;
        byp_d    = byp_q;
        usr_sr_d = usr_sr_q;
        ir_d     = ir_q;
        upd_d    = upd_q;
        stb_d    = 1'b0;
        tdo_d    = tdo_q;
        if (!trst_n_s) begin
            ir_sr_d  = '0;
            id_sr_d  = '0;
            byp_d    = 1'b0;
            usr_sr_d = '0;
            ir_d     = IDCODE_INSTR;
        end else begin
            if (tck_rise) begin
                unique case (state_q)
                    CAPTURE_IR: ir_sr_d = IR_CAPTURE;
                    SHIFT_IR:   ir_sr_d = {tdi_s, ir_sr_q[IR_WIDTH-1:1]};
                    CAPTURE_DR: begin
                        unique case (dr_sel)
                            DR_IDCODE: id_sr_d  = IDCODE_VALUE;
                            DR_USER:   usr_sr_d = user_dr_capture_data_i;
                            default:   byp_d    = 1'b0;
                        endcase
                    end
                    SHIFT_DR: begin
                        unique case (dr_sel)
                            DR_IDCODE: id_sr_d = {tdi_s, id_sr_q[31:1]};
                            // Shift form works for a single-bit user DR too.
                            DR_USER: usr_sr_d = (usr_sr_q >> 1)
                                | (USER_DR_WIDTH'(tdi_s) << (USER_DR_WIDTH - 1));
                            default: byp_d = tdi_s;
                        endcase
                    end
                    default: ;
                endcase
            end
            if (tck_fall) begin
                tdo_d = 1'b0;
                if (state_q == SHIFT_IR) begin
                    tdo_d = ir_sr_q[0];
                end else if (state_q == SHIFT_DR) begin
                    tdo_d = dr_tdo;
                end
                if (state_q == UPDATE_IR) begin
                    ir_d = ir_sr_q;
                end
                if (state_q == UPDATE_DR && dr_sel == DR_USER) begin
                    upd_d = usr_sr_q;
                    stb_d = 1'b1;
                end
            end
            if (state_q == TEST_RESET) begin
                ir_d = IDCODE_INSTR;
            end
        end
    end

    always_ff @(posedge system_clk) begin
        if (system_rst) begin
            state_q  <= TEST_RESET;
            ir_q     <= IDCODE_INSTR;
            ir_sr_q  <= '0;
            id_sr_q  <= '0;
            byp_q    <= 1'b0;
            usr_sr_q <= '0;
            upd_q    <= '0;
            stb_q    <= 1'b0;
            tdo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ir_q     <= ir_d;
            ir_sr_q  <= ir_sr_d;
            id_sr_q  <= id_sr_d;
            byp_q    <= byp_d;
            usr_sr_q <= usr_sr_d;
            upd_q    <= upd_d;
            stb_q    <= stb_d;
            tdo_q    <= tdo_d;
        end
    end

    assign jtag.jtag_tdo_o             = tdo_q;
    assign user_dr_update_data_o       = upd_q;
    assign user_dr_update_strobe_o     = stb_q;
    assign tap_state_o                 = state_q;
    assign ir_o                        = ir_q;

endmodule

// File: tb/tb_jtag_tap_responder.sv
// Bench for jtag_tap_responder: directed scenarios plus a random TMS/TDI walk.
// A queue-based TAP model predicts state, IR, TDO, update data and strobe.
module tb_jtag_tap_responder;
    import jtag_tap_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cap_data;
    logic [31:0] upd;
    logic        stb;
    logic [3:0]  st;
    logic [3:0]  ir;

    int errors;
    int checks;
    int stb_cnt;

    // Model state
    logic [3:0]  m_state;
    logic [3:0]  m_ir;
    logic        m_tdo;
    logic [31:0] m_upd;
    int          m_stb_exp;
    bit          ir_bits[$];
    bit          dr_bits[$];
    logic [63:0] tbl0;
    logic [63:0] tbl1;

    always #5 clk = ~clk;

    jtag_tap_responder_if jif ();

    jtag_tap_responder dut (
        .system_clk              (clk),
        .system_rst              (rst),
        .jtag                    (jif),
        .user_dr_capture_data_i  (cap_data),
        .user_dr_update_data_o   (upd),
        .user_dr_update_strobe_o (stb),
        .tap_state_o             (st),
        .ir_o                    (ir)
    );

    function automatic logic [31:0] q2v(input bit q[$]);
        logic [31:0] v = '0;
        foreach (q[i]) if (i < 32) v[i] = q[i];
        return v;
    endfunction

    task automatic model_reset();
        m_state = TEST_RESET;
        m_ir = 4'b0001;
        m_tdo = 1'b0;
        m_upd = '0;
        m_stb_exp = 0;
        ir_bits = {};
        dr_bits = {};
    endtask

    task automatic model_rise(input bit tms, input bit tdi);
        bit b;
        logic [31:0] v;
        case (m_state)
            CAPTURE_IR: begin
                ir_bits = {};
                ir_bits.push_back(1'b1);
                for (int i = 1; i < 4; i++) ir_bits.push_back(1'b0);
            end
            SHIFT_IR: begin
                b = ir_bits.pop_front();
                ir_bits.push_back(tdi);
            end
            CAPTURE_DR: begin
                dr_bits = {};
                if (m_ir == 4'b0001) v = 32'h149511C3;
                else v = cap_data;
                if (m_ir == 4'b0001 || m_ir == 4'b1000)
                    for (int i = 0; i < 32; i++) dr_bits.push_back(v[i]);
                else dr_bits.push_back(1'b0);
            end
            SHIFT_DR: begin
                b = dr_bits.pop_front();
                dr_bits.push_back(tdi);
            end
            default: ;
        endcase
        m_state = tms ? tbl1[m_state*4 +: 4] : tbl0[m_state*4 +: 4];
        m_stb_exp = 0;
        if (m_state == TEST_RESET) m_ir = 4'b0001;
    endtask

    task automatic model_fall();
        logic [31:0] v;
        if (m_state == UPDATE_IR) begin
            v = q2v(ir_bits);
            m_ir = v[3:0];
        end
        if (m_state == UPDATE_DR && m_ir == 4'b1000) begin
            m_upd = q2v(dr_bits);
            m_stb_exp = 1;
        end
        if (m_state == SHIFT_IR) m_tdo = ir_bits[0];
        else if (m_state == SHIFT_DR) m_tdo = dr_bits[0];
        else m_tdo = 1'b0;
    endtask

    // One full TCK period; counts strobe-high cycles across it.
    task automatic tck(input bit tms, input bit tdi);
        stb_cnt = 0;
        @(negedge clk);
        jif.jtag_tms_i = tms;
        jif.jtag_tdi_i = tdi;
        repeat (5) begin @(negedge clk); if (stb) stb_cnt++; end
        jif.jtag_tck_i = 1'b1;
        model_rise(tms, tdi);
        repeat (20) begin @(negedge clk); if (stb) stb_cnt++; end
        jif.jtag_tck_i = 1'b0;
        model_fall();
        repeat (20) begin @(negedge clk); if (stb) stb_cnt++; end
    endtask

    task automatic trst_pulse();
        stb_cnt = 0;
        @(negedge clk);
        jif.jtag_trst_i = 1'b0;
        repeat (4) begin @(negedge clk); if (stb) stb_cnt++; end
        jif.jtag_trst_i = 1'b1;
        repeat (6) begin @(negedge clk); if (stb) stb_cnt++; end
        m_state = TEST_RESET;
        m_ir = 4'b0001;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        jif.jtag_tck_i = 1'b0;
        jif.jtag_tms_i = 1'b1;
        jif.jtag_tdi_i = 1'b0;
        jif.jtag_trst_i = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        model_reset();
    endtask

    task automatic shift(input int n, input logic [31:0] din,
                         output logic [31:0] dout);
        dout = '0;
        for (int i = 0; i < n; i++) begin
            dout[i] = jif.jtag_tdo_o;
            tck(i == n - 1, din[i]);
        end
    endtask

    // From Test-Logic-Reset, load an opcode and park in Run-Test/Idle.
    task automatic load_ir(input logic [3:0] op, output logic [31:0] out);
        tck(0, 0); tck(1, 0); tck(1, 0); tck(0, 0); tck(0, 0);
        shift(4, {28'd0, op}, out);
        tck(1, 0);
        tck(0, 0);
    endtask

    task automatic test_reset();
        do_reset();
        stb_cnt = 0;
        repeat (5) begin @(negedge clk); if (stb) stb_cnt++; end
        checks++; if (st !== 4'hF) begin errors++;
            $display("FAIL reset_state got=%h exp=F", st); end
        checks++; if (ir !== 4'b0001) begin errors++;
            $display("FAIL reset_ir got=%b exp=0001", ir); end
        checks++; if (jif.jtag_tdo_o !== 1'b0) begin errors++;
            $display("FAIL reset_tdo got=%b exp=0", jif.jtag_tdo_o); end
        checks++; if (stb_cnt != 0) begin errors++;
            $display("FAIL reset_strobe got=%0d exp=0", stb_cnt); end
        checks++; if (upd !== 32'h0) begin errors++;
            $display("FAIL reset_upd got=%h exp=0", upd); end
    endtask

    task automatic test_tlr_recovery();
        do_reset();
        tck(0, 0); tck(1, 0); tck(0, 0); tck(0, 0);
        checks++; if (st !== 4'h2) begin errors++;
            $display("FAIL tlr_in_shiftdr got=%h exp=2", st); end
        repeat (5) tck(1, 0);
        checks++; if (st !== 4'hF) begin errors++;
            $display("FAIL tlr_five_tms got=%h exp=F", st); end
        tck(0, 0);
        checks++; if (st !== 4'hC) begin errors++;
            $display("FAIL tlr_to_rti got=%h exp=C", st); end
    endtask

    task automatic test_idcode();
        logic [31:0] got;
        do_reset();
        tck(0, 0); tck(1, 0); tck(0, 0); tck(0, 0);
        shift(32, 32'h0, got);
        checks++; if (got !== 32'h149511C3) begin errors++;
            $display("FAIL idcode_shift got=%h exp=149511C3", got); end
    endtask

    task automatic test_bypass();
        logic [31:0] got;
        do_reset();
        load_ir(4'b1111, got);
        checks++; if (got[3:0] !== 4'b0001) begin errors++;
            $display("FAIL bypass_ir_capture got=%b exp=0001", got[3:0]); end
        checks++; if (ir !== 4'b1111) begin errors++;
            $display("FAIL bypass_ir got=%b exp=1111", ir); end
        tck(1, 0); tck(0, 0); tck(0, 0);
        shift(4, 32'b1101, got);
        checks++; if (got[3:0] !== 4'b1010) begin errors++;
            $display("FAIL bypass_delay got=%b exp=1010", got[3:0]); end
    endtask

    task automatic test_user();
        logic [31:0] got;
        do_reset();
        load_ir(4'b1000, got);
        checks++; if (ir !== 4'b1000) begin errors++;
            $display("FAIL user_ir got=%b exp=1000", ir); end
        cap_data = 32'hDEADBEEF;
        tck(1, 0); tck(0, 0); tck(0, 0);
        shift(32, 32'h12345678, got);
        checks++; if (got !== 32'hDEADBEEF) begin errors++;
            $display("FAIL user_capture got=%h exp=DEADBEEF", got); end
        tck(1, 0);
        checks++; if (upd !== 32'h12345678) begin errors++;
            $display("FAIL user_update got=%h exp=12345678", upd); end
        checks++; if (stb_cnt != 1) begin errors++;
            $display("FAIL user_strobe got=%0d exp=1", stb_cnt); end
        tck(0, 0);
        checks++; if (stb_cnt != 0 || st !== 4'hC) begin errors++;
            $display("FAIL user_after got=%0d/%h exp=0/C", stb_cnt, st); end
    endtask

    task automatic test_trst();
        logic [31:0] got;
        logic [31:0] val;
        do_reset();
        load_ir(4'b1000, got);
        cap_data = $urandom;
        val = $urandom;
        tck(1, 0); tck(0, 0); tck(0, 0);
        shift(32, val, got);
        tck(1, 0); tck(0, 0);
        tck(1, 0); tck(0, 0); tck(0, 0);
        repeat (10) tck(0, 1'($urandom_range(0, 1)));
        trst_pulse();
        checks++; if (st !== 4'hF) begin errors++;
            $display("FAIL trst_state got=%h exp=F", st); end
        checks++; if (ir !== 4'b0001) begin errors++;
            $display("FAIL trst_ir got=%b exp=0001", ir); end
        checks++; if (upd !== val) begin errors++;
            $display("FAIL trst_upd got=%h exp=%h", upd, val); end
        checks++; if (stb_cnt != 0) begin errors++;
            $display("FAIL trst_strobe got=%0d exp=0", stb_cnt); end
    endtask

    task automatic test_random_walk();
        bit tms;
        do_reset();
        for (int n = 0; n < 300; n++) begin
            cap_data = $urandom;
            if ($urandom_range(0, 59) == 0) begin
                trst_pulse();
            end else begin
                tms = ($urandom_range(0, 9) < 4);
                tck(tms, 1'($urandom_range(0, 1)));
            end
            checks++; if (st !== m_state) begin errors++;
                $display("FAIL walk_state step=%0d got=%h exp=%h", n, st, m_state); end
            checks++; if (ir !== m_ir) begin errors++;
                $display("FAIL walk_ir step=%0d got=%b exp=%b", n, ir, m_ir); end
            checks++; if (jif.jtag_tdo_o !== m_tdo) begin errors++;
                $display("FAIL walk_tdo step=%0d got=%b exp=%b", n, jif.jtag_tdo_o, m_tdo); end
            checks++; if (upd !== m_upd) begin errors++;
                $display("FAIL walk_upd step=%0d got=%h exp=%h", n, upd, m_upd); end
            checks++; if (stb_cnt != m_stb_exp) begin errors++;
                $display("FAIL walk_strobe step=%0d got=%0d exp=%0d", n, stb_cnt, m_stb_exp); end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        cap_data = '0;
        rst = 1'b1;
        jif.jtag_tck_i = 1'b0;
        jif.jtag_tms_i = 1'b1;
        jif.jtag_tdi_i = 1'b0;
        jif.jtag_trst_i = 1'b1;
        // Nibble i of tbl0/tbl1 is the next state from state i with TMS=0/1.
        tbl0 = 64'hCACC_BABA_62CE_3232;
        tbl1 = 64'hF977_89DD_417F_0155;
        model_reset();
        test_reset();
        test_tlr_recovery();
        test_idcode();
        test_bypass();
        test_user();
        test_trst();
        test_random_walk();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
